// File: rtl/store_buffer.sv
// Store buffer in front of the data memory. Stores are posted into a small
// FIFO and drained one per cycle whenever the memory port is free. Loads are
// served one at a time; a load whose word is still buffered waits until the
// matching entries have drained so it never observes stale memory contents.
//
// Handshakes:
//   store: a store transfers on a rising edge where st_valid && st_ready.
//          st_ready depends only on registered state, never on st_valid.
//   load : ld_valid is raised with ld_address/ld_byte and held until the
//          single-cycle ld_done pulse; ld_data is valid in that cycle.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_address,
  input  logic [DATA_W-1:0]        st_data,
  input  logic                     st_byte,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_address,
  input  logic                     ld_byte,
  output logic [DATA_W-1:0]        ld_data,
  output logic                     ld_done,
  output logic [ADDR_W-1:0]        address,
  output logic [DATA_W-1:0]        write_data,
  output logic                     byteOperations,
  output logic                     memRead,
  output logic                     memWrite,
  input  logic [DATA_W-1:0]        read_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] L_IDLE  = 2'd0;
  localparam logic [1:0] L_DRAIN = 2'd1;
  localparam logic [1:0] L_READ  = 2'd2;
  localparam logic [1:0] L_DONE  = 2'd3;

  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic              fifo_byte [DEPTH];

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [1:0]        ld_state;
  logic [1:0]        ld_state_nxt;
  logic              hazard;
  logic              push;
  logic              pop;

  assign empty    = (count == '0);
  // Stores are held off while a load waits on a hazard so the load cannot starve.
  assign st_ready = (count != CNT_W'(DEPTH)) && (ld_state != L_DRAIN);
  assign push     = st_valid && st_ready;
  assign pop      = memWrite;
  assign ld_done  = (ld_state == L_DONE);

  // Word-granular hazard: any occupied entry in the same 32-bit word as the load.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) &&
          (fifo_addr[head + PTR_W'(i)][ADDR_W-1:2] == ld_address[ADDR_W-1:2])) begin
        hazard = 1'b1;
      end
    end
  end

  // Memory port arbitration: the load read wins, otherwise drain the head entry.
  always_comb begin
    address        = '0;
    write_data     = '0;
    byteOperations = 1'b0;
    memRead        = 1'b0;
    memWrite       = 1'b0;
    if (ld_state == L_READ) begin
      memRead        = 1'b1;
      address        = ld_address;
      byteOperations = ld_byte;
    end else if (!empty) begin
      memWrite       = 1'b1;
      address        = fifo_addr[head];
      write_data     = fifo_data[head];
      byteOperations = fifo_byte[head];
    end
  end

  // Entry storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[tail] <= st_address;
      fifo_data[tail] <= st_data;
      fifo_byte[tail] <= st_byte;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Load FSM next-state: wait out hazards, read for one cycle, then report.
  always_comb begin
    ld_state_nxt = ld_state;
    case (ld_state)
      L_IDLE:  if (ld_valid) ld_state_nxt = hazard ? L_DRAIN : L_READ;
      L_DRAIN: if (!hazard)  ld_state_nxt = L_READ;
      L_READ:  ld_state_nxt = L_DONE;
      default: ld_state_nxt = L_IDLE;
    endcase
  end

  // Load FSM state and the registered load result captured during L_READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_state <= L_IDLE;
      ld_data  <= '0;
    end else begin
      ld_state <= ld_state_nxt;
      if (ld_state == L_READ) ld_data <= read_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a little-endian byte memory model,
// an in-order write scoreboard and hand-computed expectations.
module tb_store_buffer;

  localparam int E_W = 51;  // {address[17:0], data[31:0], byte}

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [17:0] st_address;
  logic [31:0] st_data;
  logic        st_byte;
  logic        ld_valid;
  logic [17:0] ld_address;
  logic        ld_byte;
  logic [31:0] ld_data;
  logic        ld_done;
  logic [17:0] address;
  logic [31:0] write_data;
  logic        byteOperations;
  logic        memRead;
  logic        memWrite;
  logic [31:0] read_data;
  logic        empty;
  logic [2:0]  count;

  logic [E_W-1:0] exp_q[$];
  logic [7:0]     mem [0:255];
  int             n_checks;
  int             n_errors;

  store_buffer #(.DEPTH(4), .ADDR_W(18), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_address(st_address),
    .st_data(st_data), .st_byte(st_byte),
    .ld_valid(ld_valid), .ld_address(ld_address), .ld_byte(ld_byte),
    .ld_data(ld_data), .ld_done(ld_done),
    .address(address), .write_data(write_data), .byteOperations(byteOperations),
    .memRead(memRead), .memWrite(memWrite), .read_data(read_data),
    .empty(empty), .count(count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: byte array, each byte initialised to its own address
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i[7:0];
  end

  always_comb begin
    if (byteOperations)
      read_data = {24'h0, mem[address[7:0]]};
    else
      read_data = {mem[{address[7:2], 2'd3}], mem[{address[7:2], 2'd2}],
                   mem[{address[7:2], 2'd1}], mem[{address[7:2], 2'd0}]};
  end

  always @(posedge clk) begin
    if (memWrite) begin
      if (byteOperations) begin
        mem[address[7:0]] <= write_data[7:0];
      end else begin
        mem[{address[7:2], 2'd0}] <= write_data[7:0];
        mem[{address[7:2], 2'd1}] <= write_data[15:8];
        mem[{address[7:2], 2'd2}] <= write_data[23:16];
        mem[{address[7:2], 2'd3}] <= write_data[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every drained write must match the oldest accepted store,
  // and a load read may never target a word still waiting to drain
  always @(negedge clk) begin
    if (rst_n) begin
      logic [E_W-1:0] e;
      int hz;
      check("mem_excl", memRead && memWrite, 0);
      if (memWrite) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", address, e[50:33]);
          check("wr_data", write_data, e[32:1]);
          check("wr_byte", byteOperations, e[0]);
        end
      end
      if (memRead) begin
        hz = 0;
        foreach (exp_q[i]) if (exp_q[i][50:35] == address[17:2]) hz++;
        check("rd_hazard", hz, 0);
      end
    end
  end

  // driver tasks
  task automatic set_ld(input logic lv, input logic [17:0] la, input logic lb);
    ld_valid   = lv;
    ld_address = la;
    ld_byte    = lb;
  endtask

  // Present one store (or none) for one cycle; returns whether it was accepted.
  task automatic step_st(input logic sv, input logic [17:0] sa, input logic [31:0] sd,
                         input logic sb, output logic acc);
    st_valid   = sv;
    st_address = sa;
    st_data    = sd;
    st_byte    = sb;
    acc = sv && st_ready;
    if (acc) exp_q.push_back({sa, sd, sb});
    @(negedge clk);
  endtask

  task automatic idle();
    logic a;
    step_st(1'b0, 18'h0, 32'h0, 1'b0, a);
  endtask

  task automatic do_load(input logic [17:0] la, input logic lb,
                         output logic [31:0] data, output int lat);
    set_ld(1'b1, la, lb);
    lat = 0;
    do begin
      idle();
      lat++;
    end while (!ld_done && lat < 20);
    data = ld_data;
    set_ld(1'b0, 18'h0, 1'b0);
    idle();
  endtask

  task automatic wait_empty(input string tag);
    int g;
    g = 0;
    while (!empty && g < 50) begin
      idle();
      g++;
    end
    check(tag, empty, 1);
  endtask

  initial begin
    logic        a;
    logic [31:0] d;
    logic [2:0]  c_before;
    int          lat;
    int          stalls;
    int          idx;
    int          guard;

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    st_valid = 1'b0; st_address = '0; st_data = '0; st_byte = 1'b0;
    set_ld(1'b0, 18'h0, 1'b0);
    repeat (2) @(negedge clk);

    // reset values
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_st_ready", st_ready, 1);
    check("rst_memwrite", memWrite, 0);
    check("rst_memread", memRead, 0);
    check("rst_address", address, 0);
    check("rst_ld_done", ld_done, 0);
    check("rst_ld_data", ld_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // three stores drain one per cycle in order
    step_st(1'b1, 18'h10, 32'hAABBCCDD, 1'b0, a);
    check("t1_cnt_a", count, 1); check("t1_wr_a", memWrite, 1);
    step_st(1'b1, 18'h14, 32'h11223344, 1'b0, a);
    check("t1_cnt_b", count, 1); check("t1_wr_b", memWrite, 1);
    step_st(1'b1, 18'h19, 32'h0000005A, 1'b1, a);
    check("t1_cnt_c", count, 1); check("t1_wr_c", memWrite, 1);
    idle();
    check("t1_cnt_0", count, 0); check("t1_empty", empty, 1); check("t1_wr_0", memWrite, 0);
    do_load(18'h10, 1'b0, d, lat);
    check("t1_ld_word", d, 32'hAABBCCDD); check("t1_ld_lat", lat, 2);
    do_load(18'h19, 1'b1, d, lat);
    check("t1_ld_byte", d, 32'h5A);

    // five back-to-back stores with the port free never stall
    stalls = 0;
    for (int i = 0; i < 5; i++) begin
      step_st(1'b1, 18'h40 + 18'(4 * i), 32'hC0DE0000 + i, 1'b0, a);
      if (!a) stalls++;
    end
    check("t2_free_stalls", stalls, 0);
    check("t2_free_cnt", count, 1);
    idle();
    wait_empty("t2_free_empty");

    // continuous loads block one drain in three, filling the FIFO
    set_ld(1'b1, 18'h80, 1'b0);
    idx = 0; stalls = 0; guard = 0;
    while (idx < 12 && guard < 40) begin
      c_before = count;
      step_st(1'b1, 18'h40 + 18'(4 * idx), 32'hF0000000 + idx, 1'b0, a);
      if (a) idx++;
      else begin
        stalls++;
        check("t2_stall_cnt", c_before, 4);
      end
      if (ld_done) check("t2_ld_data", ld_data, 32'h83828180);
      guard++;
    end
    check("t2_stores_sent", idx, 12);
    check("t2_stalls", stalls, 2);
    guard = 0;
    while (!ld_done && guard < 10) begin idle(); guard++; end
    set_ld(1'b0, 18'h0, 1'b0);
    idle();
    wait_empty("t2_full_empty");
    check("t2_sb_left", exp_q.size(), 0);

    // hazard load: waits in drain until the 0x20 word has been written
    step_st(1'b1, 18'h30, 32'h30303030, 1'b0, a);
    step_st(1'b1, 18'h34, 32'h34343434, 1'b0, a);
    step_st(1'b1, 18'h38, 32'h38383838, 1'b0, a);
    step_st(1'b1, 18'h20, 32'hDEADBEEF, 1'b0, a);
    set_ld(1'b1, 18'h22, 1'b1);
    idle();
    check("t3_drain_st_ready", st_ready, 0);
    check("t3_drain_rd", memRead, 0);
    check("t3_drain_cnt", count, 0);
    idle();
    check("t3_rd", memRead, 1);
    check("t3_rd_addr", address, 18'h22);
    check("t3_rd_byte", byteOperations, 1);
    idle();
    check("t3_done", ld_done, 1);
    check("t3_ld_data", ld_data, 32'h000000AD);
    set_ld(1'b0, 18'h0, 1'b0);
    idle();
    check("t3_done_clr", ld_done, 0);
    check("t3_st_ready", st_ready, 1);

    // push/pop at count 2 across pointer wrap, write order 0..9
    set_ld(1'b1, 18'h84, 1'b0);
    step_st(1'b1, 18'h00, 32'h100, 1'b0, a);
    check("t4_rd_pause", memRead, 1);
    check("t4_wr_pause", memWrite, 0);
    check("t4_cnt1", count, 1);
    step_st(1'b1, 18'h04, 32'h101, 1'b0, a);
    check("t4_ld_done", ld_done, 1);
    check("t4_ld_data", ld_data, 32'h87868584);
    check("t4_cnt2", count, 2);
    set_ld(1'b0, 18'h0, 1'b0);
    for (int i = 2; i < 10; i++) begin
      step_st(1'b1, 18'(4 * i), 32'h100 + i, 1'b0, a);
      check("t4_cnt_steady", count, 2);
    end
    idle();
    wait_empty("t4_empty");
    check("t4_sb_left", exp_q.size(), 0);

    // asynchronous reset while a load waits in drain with three entries
    set_ld(1'b1, 18'h90, 1'b0);
    step_st(1'b1, 18'h50, 32'h50, 1'b0, a);
    step_st(1'b1, 18'h54, 32'h54, 1'b0, a);
    check("t5_ld1_done", ld_done, 1);
    check("t5_ld1_data", ld_data, 32'h93929190);
    check("t5_cnt_a", count, 2);
    set_ld(1'b0, 18'h0, 1'b0);
    step_st(1'b1, 18'h58, 32'h58, 1'b0, a);
    check("t5_cnt_b", count, 2);
    set_ld(1'b1, 18'h94, 1'b0);
    step_st(1'b1, 18'h5C, 32'h5C, 1'b0, a);
    step_st(1'b1, 18'h60, 32'h60, 1'b0, a);
    check("t5_ld2_data", ld_data, 32'h97969594);
    check("t5_cnt_c", count, 3);
    set_ld(1'b0, 18'h0, 1'b0);
    step_st(1'b1, 18'h64, 32'h64, 1'b0, a);
    set_ld(1'b1, 18'h64, 1'b0);
    step_st(1'b1, 18'h68, 32'h68, 1'b0, a);
    check("t5_drain_cnt", count, 3);
    check("t5_drain_st_ready", st_ready, 0);
    check("t5_drain_wr", memWrite, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_wr", memWrite, 0);
    check("t5_rst_addr", address, 0);
    check("t5_rst_wdata", write_data, 0);
    check("t5_rst_cnt", count, 0);
    check("t5_rst_empty", empty, 1);
    check("t5_rst_ld_data", ld_data, 0);
    exp_q.delete();
    st_valid = 1'b0;
    set_ld(1'b0, 18'h0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      check("t5_post_wr", memWrite, 0);
      check("t5_post_empty", empty, 1);
      check("t5_post_done", ld_done, 0);
    end
    do_load(18'h94, 1'b0, d, lat);
    check("t5_post_ld_lat", lat, 2);
    check("t5_post_ld_data", d, 32'h97969594);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
